// File: rtl/vxe_cu_fetch_unit.sv
// VxE control-unit instruction fetch: streams 64-bit words from a programmed
// address into a small in-order FIFO, with halt/unhalt/stop-drain control.
module vxe_cu_fetch_unit #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          i_start,
  input  logic [36:0]   i_pgm_addr,
  input  logic          i_halt,
  input  logic          i_unhalt,
  input  logic          i_stop_drain,
  output logic          o_busy,
  output logic          o_flt_fetch,
  output logic [36:0]   o_flt_addr,
  output logic          o_rq_vld,
  output logic [36:0]   o_rq_addr,
  input  logic          i_rq_rdy,
  input  logic          i_rs_vld,
  input  logic          i_rs_err,
  input  logic [63:0]   i_rs_data,
  output logic          o_instr_vld,
  output logic [63:0]   o_instr,
  input  logic          i_instr_rd
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = FIFO_DEPTH[CW:0];

  typedef enum logic [1:0] {IDLE, FETCH, HALT, DRAIN} state_e;

  state_e        state_q, state_d;
  logic          busy_q;
  logic [36:0]   pc_q, pc_d;
  logic [36:0]   rs_pc_q, rs_pc_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          flt_q, flt_d;
  logic [36:0]   flt_addr_q, flt_addr_d;
  logic [63:0]   mem_q [FIFO_DEPTH];

  logic          active;
  logic [CW:0]   credit_sum;
  logic          rq_vld;
  logic          rq_fire;
  logic          rs_fire;
  logic          instr_vld;
  logic          pop;
  logic          stop;
  logic          err;
  logic          push;

  assign active     = (state_q == FETCH) || (state_q == HALT);
  assign credit_sum = {1'b0, outst_q} + {1'b0, cnt_q};
  // Every accepted request owns a FIFO slot, so responses never overflow.
  assign rq_vld     = (state_q == FETCH) && (credit_sum < DEPTH_C);
  assign rq_fire    = rq_vld && i_rq_rdy;
  assign rs_fire    = i_rs_vld && (outst_q != '0);
  assign instr_vld  = active && (cnt_q != '0);
  assign pop        = instr_vld && i_instr_rd;
  assign stop       = i_stop_drain && (state_q != IDLE);
  assign err        = active && rs_fire && i_rs_err && !stop;
  assign push       = active && rs_fire && !i_rs_err && !stop;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    rs_pc_d    = rs_pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    flt_d      = 1'b0;
    flt_addr_d = flt_addr_q;
    outst_d    = outst_q + CW'(rq_fire) - CW'(rs_fire);
    cnt_d      = cnt_q + CW'(push) - CW'(pop);

    if (rq_fire) pc_d = pc_q + 37'd1;
    if (rs_fire) rs_pc_d = rs_pc_q + 37'd1;
    if (push)    wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + PW'(1);
    if (err) begin
      flt_d      = 1'b1;
      flt_addr_d = rs_pc_q;
    end

    case (state_q)
      IDLE: begin
        if (i_start) begin
          pc_d    = i_pgm_addr;
          rs_pc_d = i_pgm_addr;
          state_d = FETCH;
        end
      end
      FETCH, HALT: begin
        if (stop || err) begin
          // Flush on entry; with nothing in flight drain completes immediately.
          cnt_d    = '0;
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          state_d  = (outst_d == '0) ? IDLE : DRAIN;
        end else if (i_halt) begin
          state_d = HALT;
        end else if (i_unhalt) begin
          state_d = FETCH;
        end
      end
      DRAIN: begin
        if (outst_d == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      pc_q       <= '0;
      rs_pc_q    <= '0;
      outst_q    <= '0;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      flt_q      <= 1'b0;
      flt_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= (state_d != IDLE);
      pc_q       <= pc_d;
      rs_pc_q    <= rs_pc_d;
      outst_q    <= outst_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      flt_q      <= flt_d;
      flt_addr_q <= flt_addr_d;
    end
  end

  // Storage holds data only; validity is tracked entirely by cnt_q.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= i_rs_data;
  end

  assign o_busy      = busy_q;
  assign o_flt_fetch = flt_q;
  assign o_flt_addr  = flt_addr_q;
  assign o_rq_vld    = rq_vld;
  assign o_rq_addr   = pc_q;
  assign o_instr_vld = instr_vld;
  assign o_instr     = instr_vld ? mem_q[rd_ptr_q] : 64'd0;

endmodule
